// File: rtl/e_mdu_if.sv
// Request/result bundle between the execute stage and the multiply/divide unit.
// master drives the request side, slave is the MDU itself.
interface e_mdu_if;
   logic        Start;
   logic [3:0]  MDUOp;
   logic [31:0] A;
   logic [31:0] B;
   logic        Busy;
   logic [31:0] HI;
   logic [31:0] LO;
   logic [31:0] MDUOut;

   modport master (output Start, MDUOp, A, B, input Busy, HI, LO, MDUOut);
   modport slave  (input Start, MDUOp, A, B, output Busy, HI, LO, MDUOut);
endinterface

// File: rtl/e_mdu.sv
// Execute-stage multiply/divide unit: multi-cycle mult/div with HI/LO registers,
// operands captured at start into shadow registers and committed when the countdown ends.
module e_mdu #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input logic   clk,
   input logic   reset,
   e_mdu_if.slave bus
);

   localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int CNT_W      = $clog2(MAX_CYCLES + 1);
   localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
   localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);

   localparam logic [3:0] OP_MULT  = 4'd1;
   localparam logic [3:0] OP_MULTU = 4'd2;
   localparam logic [3:0] OP_DIV   = 4'd3;
   localparam logic [3:0] OP_DIVU  = 4'd4;
   localparam logic [3:0] OP_MTHI  = 4'd5;
   localparam logic [3:0] OP_MTLO  = 4'd6;
   localparam logic [3:0] OP_MFHI  = 4'd7;
   localparam logic [3:0] OP_MFLO  = 4'd8;

   typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_t;

   state_t             state_r, state_s;
   logic [CNT_W-1:0]   cnt_r, cnt_s;
   logic [31:0]        hi_r, hi_s, lo_r, lo_s;
   logic [31:0]        pend_hi_r, pend_hi_s, pend_lo_r, pend_lo_s;
   logic               pend_wr_r, pend_wr_s;
   logic               busy_r, busy_s;

   logic signed [63:0] sop_a_s, sop_b_s, smul_s;
   logic [63:0]        umul_s;
   logic               div_ovf_s, div_zero_s;
   logic [31:0]        sdiv_b_s, udiv_b_s;
   logic signed [31:0] sdiv_q_s, sdiv_r_s;
   logic [31:0]        div_q_s, div_r_s, udiv_q_s, udiv_r_s;
   logic [31:0]        mdu_out_s;

   // Candidate results for every multi-cycle op, computed from the live operands.
   // The divisor is swapped for 1 on the two cases whose hardware quotient is undefined.
   always_comb begin
      sop_a_s    = {{32{bus.A[31]}}, bus.A};
      sop_b_s    = {{32{bus.B[31]}}, bus.B};
      smul_s     = sop_a_s * sop_b_s;
      umul_s     = {32'd0, bus.A} * {32'd0, bus.B};
      div_zero_s = (bus.B == 32'd0);
      div_ovf_s  = (bus.A == 32'h8000_0000) && (bus.B == 32'hFFFF_FFFF);
      if (div_zero_s || div_ovf_s) begin
         sdiv_b_s = 32'd1;
      end else begin
         sdiv_b_s = bus.B;
      end
      if (div_zero_s) begin
         udiv_b_s = 32'd1;
      end else begin
         udiv_b_s = bus.B;
      end
      sdiv_q_s = $signed(bus.A) / $signed(sdiv_b_s);
      sdiv_r_s = $signed(bus.A) % $signed(sdiv_b_s);
      udiv_q_s = bus.A / udiv_b_s;
      udiv_r_s = bus.A % udiv_b_s;
      if (div_ovf_s) begin
         div_q_s = 32'h8000_0000;
         div_r_s = 32'd0;
      end else begin
         div_q_s = sdiv_q_s;
         div_r_s = sdiv_r_s;
      end
   end

   // Next-state, countdown, shadow capture and HI/LO update.
   always_comb begin
      state_s   = state_r;
      cnt_s     = cnt_r;
      hi_s      = hi_r;
      lo_s      = lo_r;
      pend_hi_s = pend_hi_r;
      pend_lo_s = pend_lo_r;
      pend_wr_s = pend_wr_r;
      case (state_r)
         ST_IDLE: begin
            if (bus.Start) begin
               case (bus.MDUOp)
                  OP_MULT: begin
                     state_s   = ST_RUN;
                     cnt_s     = MULT_LOAD;
                     pend_hi_s = smul_s[63:32];
                     pend_lo_s = smul_s[31:0];
                     pend_wr_s = 1'b1;
                  end
                  OP_MULTU: begin
                     state_s   = ST_RUN;
                     cnt_s     = MULT_LOAD;
                     pend_hi_s = umul_s[63:32];
                     pend_lo_s = umul_s[31:0];
                     pend_wr_s = 1'b1;
                  end
                  OP_DIV: begin
                     state_s   = ST_RUN;
                     cnt_s     = DIV_LOAD;
                     pend_hi_s = div_r_s;
                     pend_lo_s = div_q_s;
                     pend_wr_s = !div_zero_s;
                  end
                  OP_DIVU: begin
                     state_s   = ST_RUN;
                     cnt_s     = DIV_LOAD;
                     pend_hi_s = udiv_r_s;
                     pend_lo_s = udiv_q_s;
                     pend_wr_s = !div_zero_s;
                  end
                  OP_MTHI: hi_s    = bus.A;
                  OP_MTLO: lo_s    = bus.A;
                  default: state_s = ST_IDLE;
               endcase
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_RUN: begin
            // Requests arriving here are dropped; only the countdown advances.
            if (cnt_r == CNT_ONE) begin
               state_s = ST_IDLE;
               cnt_s   = CNT_ZERO;
               if (pend_wr_r) begin
                  hi_s = pend_hi_r;
                  lo_s = pend_lo_r;
               end else begin
                  hi_s = hi_r;
                  lo_s = lo_r;
               end
            end else begin
               cnt_s = cnt_r - CNT_ONE;
            end
         end
         default: state_s = ST_IDLE;
      endcase
      busy_s = (state_s == ST_RUN);
   end

   // State, countdown, shadows and architectural HI/LO.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r   <= ST_IDLE;
         cnt_r     <= CNT_ZERO;
         hi_r      <= 32'd0;
         lo_r      <= 32'd0;
         pend_hi_r <= 32'd0;
         pend_lo_r <= 32'd0;
         pend_wr_r <= 1'b0;
         busy_r    <= 1'b0;
      end else begin
         state_r   <= state_s;
         cnt_r     <= cnt_s;
         hi_r      <= hi_s;
         lo_r      <= lo_s;
         pend_hi_r <= pend_hi_s;
         pend_lo_r <= pend_lo_s;
         pend_wr_r <= pend_wr_s;
         busy_r    <= busy_s;
      end
   end

   // Read port: only ever shows committed HI/LO.
   always_comb begin
      case (bus.MDUOp)
         OP_MFHI: mdu_out_s = hi_r;
         OP_MFLO: mdu_out_s = lo_r;
         default: mdu_out_s = 32'd0;
      endcase
   end

   assign bus.Busy   = busy_r;
   assign bus.HI     = hi_r;
   assign bus.LO     = lo_r;
   assign bus.MDUOut = mdu_out_s;

endmodule

// File: tb/tb_e_mdu.sv
// Directed bench for e_mdu: an arithmetic reference model checked every cycle,
// plus hand-computed expectations for each scenario.
module tb_e_mdu;

   logic clk = 1'b0;
   logic reset = 1'b0;
   e_mdu_if bus();

   e_mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int vectors = 0;
   int errors  = 0;
   bit check_en = 1'b0;

   // Reference state: committed HI/LO, cycles of Busy left, and the pending result.
   logic [31:0] m_hi = 32'd0, m_lo = 32'd0, p_hi = 32'd0, p_lo = 32'd0;
   bit          p_wr = 1'b0;
   int          m_left = 0;

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] m_out();
      case (bus.MDUOp)
         4'd7:    return m_hi;
         4'd8:    return m_lo;
         default: return 32'd0;
      endcase
   endfunction

   task automatic m_clear();
      m_hi = 32'd0; m_lo = 32'd0; p_hi = 32'd0; p_lo = 32'd0; p_wr = 1'b0; m_left = 0;
   endtask

   // Advance one clock edge, updating the model from the inputs seen at that edge.
   task automatic tick();
      logic [31:0] nh = m_hi, nl = m_lo, ph = p_hi, pl = p_lo;
      bit          pw = p_wr;
      int          nleft = m_left;
      longint      sa, sb, q, r;
      logic [63:0] prod;
      sa = longint'($signed(bus.A));
      sb = longint'($signed(bus.B));
      if (m_left > 0) begin
         if (m_left == 1 && p_wr) begin
            nh = p_hi;
            nl = p_lo;
         end
         nleft = m_left - 1;
      end else if (bus.Start) begin
         case (bus.MDUOp)
            4'd1: begin prod = sa * sb; ph = prod[63:32]; pl = prod[31:0]; pw = 1'b1; nleft = 5; end
            4'd2: begin
               prod = {32'd0, bus.A} * {32'd0, bus.B};
               ph = prod[63:32]; pl = prod[31:0]; pw = 1'b1; nleft = 5;
            end
            4'd3: begin
               pw = (bus.B != 32'd0);
               if (pw) begin q = sa / sb; r = sa % sb; ph = r[31:0]; pl = q[31:0]; end
               nleft = 10;
            end
            4'd4: begin
               pw = (bus.B != 32'd0);
               if (pw) begin pl = bus.A / bus.B; ph = bus.A % bus.B; end
               nleft = 10;
            end
            4'd5:    nh = bus.A;
            4'd6:    nl = bus.A;
            default: ;
         endcase
      end
      @(posedge clk);
      if (reset) begin
         m_clear();
      end else begin
         m_hi = nh; m_lo = nl; p_hi = ph; p_lo = pl; p_wr = pw; m_left = nleft;
      end
      #1;
   endtask

   // Per-cycle comparison against the model.
   always @(negedge clk) begin
      if (check_en) begin
         chk("busy", {31'd0, bus.Busy}, {31'd0, (m_left > 0)});
         chk("hi", bus.HI, m_hi);
         chk("lo", bus.LO, m_lo);
         chk("mduout", bus.MDUOut, m_out());
      end
   end

   task automatic issue(logic [3:0] op, logic [31:0] a, logic [31:0] b);
      bus.Start = 1'b1; bus.MDUOp = op; bus.A = a; bus.B = b;
      tick();
      bus.Start = 1'b0; bus.MDUOp = 4'd0; bus.A = 32'hA5A5_5A5A; bus.B = 32'h0F0F_F0F0;
   endtask

   task automatic wait_idle(output int n);
      n = 0;
      while (bus.Busy === 1'b1 && n < 40) begin
         tick();
         n++;
      end
      chk("busy_drop", {31'd0, bus.Busy}, 32'd0);
   endtask

   task automatic read_check(string nm, logic [31:0] eh, logic [31:0] el);
      chk({nm, "_hi"}, bus.HI, eh);
      chk({nm, "_lo"}, bus.LO, el);
      bus.MDUOp = 4'd7;
      #1 chk({nm, "_mfhi"}, bus.MDUOut, eh);
      bus.MDUOp = 4'd8;
      #1 chk({nm, "_mflo"}, bus.MDUOut, el);
      bus.MDUOp = 4'd0;
   endtask

   initial begin
      int n;
      bus.Start = 1'b0; bus.MDUOp = 4'd0; bus.A = 32'd0; bus.B = 32'd0;

      // Reset asserted mid-cycle.
      @(posedge clk);
      #3 reset = 1'b1;
      m_clear();
      #1;
      chk("rst_busy", {31'd0, bus.Busy}, 32'd0);
      chk("rst_hi", bus.HI, 32'd0);
      chk("rst_lo", bus.LO, 32'd0);
      chk("rst_mduout", bus.MDUOut, 32'd0);
      tick();
      tick();
      reset = 1'b0;
      check_en = 1'b1;

      issue(4'd1, 32'hFFFF_FFFE, 32'd3);
      wait_idle(n);
      chk("mult_cycles", n, 32'd5);
      read_check("mult", 32'hFFFF_FFFF, 32'hFFFF_FFFA);

      issue(4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      wait_idle(n);
      chk("multu_cycles", n, 32'd5);
      read_check("multu", 32'hFFFF_FFFE, 32'h0000_0001);

      issue(4'd3, 32'hFFFF_FFF9, 32'd2);
      wait_idle(n);
      chk("div_cycles", n, 32'd10);
      read_check("div", 32'hFFFF_FFFF, 32'hFFFF_FFFD);

      issue(4'd4, 32'd7, 32'd2);
      wait_idle(n);
      read_check("divu", 32'd1, 32'd3);

      issue(4'd5, 32'h0000_1234, 32'd0);
      chk("mthi_nobusy", {31'd0, bus.Busy}, 32'd0);
      chk("mthi", bus.HI, 32'h0000_1234);
      issue(4'd6, 32'h0000_5678, 32'd0);
      chk("mtlo", bus.LO, 32'h0000_5678);
      issue(4'd3, 32'h0000_0099, 32'd0);
      wait_idle(n);
      chk("div0_cycles", n, 32'd10);
      read_check("div0", 32'h0000_1234, 32'h0000_5678);

      issue(4'd3, 32'h8000_0000, 32'hFFFF_FFFF);
      wait_idle(n);
      read_check("divovf", 32'd0, 32'h8000_0000);

      // MTHI pulsed while a DIV is running must be ignored.
      issue(4'd3, 32'd100, 32'd7);
      tick();
      tick();
      bus.Start = 1'b1; bus.MDUOp = 4'd5; bus.A = 32'h0000_DEAD;
      tick();
      bus.Start = 1'b0; bus.MDUOp = 4'd0;
      chk("busy_ignore_hi", bus.HI, 32'h0000_0000);
      wait_idle(n);
      chk("div_sched", n, 32'd7);
      read_check("div_busy", 32'd2, 32'd14);

      // Back-to-back MULT in the cycle right after Busy drops.
      issue(4'd1, 32'h0001_0000, 32'hFFFF_0000);
      chk("b2b_accept", {31'd0, bus.Busy}, 32'd1);
      wait_idle(n);
      chk("b2b_cycles", n, 32'd5);
      read_check("b2b", 32'hFFFF_FFFF, 32'h0000_0000);

      // Reset in the middle of a DIVU.
      issue(4'd4, 32'd100, 32'd7);
      tick();
      tick();
      tick();
      #2 reset = 1'b1;
      m_clear();
      #1;
      chk("midrst_busy", {31'd0, bus.Busy}, 32'd0);
      chk("midrst_hi", bus.HI, 32'd0);
      chk("midrst_lo", bus.LO, 32'd0);
      tick();
      reset = 1'b0;
      repeat (12) tick();
      chk("nolate_busy", {31'd0, bus.Busy}, 32'd0);
      chk("nolate_hi", bus.HI, 32'd0);
      chk("nolate_lo", bus.LO, 32'd0);

      check_en = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
